// File: rtl/mag_comp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package mag_comp_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } compState;

  // Result codes as presented on {pmq_out, pmeq_out}
  localparam logic [1:0] RES_EQ   = 2'b11;
  localparam logic [1:0] RES_GT   = 2'b10;
  localparam logic [1:0] RES_LT   = 2'b01;
  localparam logic [1:0] RES_NONE = 2'b00;

endpackage

// File: rtl/mag_comp_chunk.sv
// Combinational compare of one CHUNK-bit slice. When signedMsb is set the
// top bit of both slices is inverted, which turns a two's-complement sign
// bit into an ordinary unsigned magnitude bit for the most-significant slice.
module mag_comp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             signedMsb,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] aAdj;
  logic [CHUNK-1:0] bAdj;

  // Bias the sign bit when needed, then do a plain unsigned compare
  always_comb begin
    aAdj = a;
    bAdj = b;
    if (signedMsb) begin
      aAdj[CHUNK-1] = ~a[CHUNK-1];
      bAdj[CHUNK-1] = ~b[CHUNK-1];
    end
    gt = (aAdj > bAdj);
    lt = (aAdj < bAdj);
  end

endmodule

// File: rtl/mag_comp_seq.sv
// Sequential magnitude comparator: walks the operands one chunk per clock,
// most-significant chunk first, and exits as soon as a chunk differs.
module mag_comp_seq
  import mag_comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             pmq_out,
  output logic             pmeq_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  compState                      state;
  logic [NCHUNK-1:0][CHUNK-1:0]  pReg;
  logic [NCHUNK-1:0][CHUNK-1:0]  qReg;
  logic                          signedReg;
  logic [IDXW-1:0]               idx;
  logic [1:0]                    result;

  logic [CHUNK-1:0] pChunk;
  logic [CHUNK-1:0] qChunk;
  logic             isMsb;
  logic             chunkGt;
  logic             chunkLt;

  assign pChunk = pReg[idx];
  assign qChunk = qReg[idx];
  assign isMsb  = (idx == IDXW'(NCHUNK - 1));

  mag_comp_chunk #(
    .CHUNK(CHUNK)
  ) chunkCmp (
    .a        (pChunk),
    .b        (qChunk),
    .signedMsb(signedReg & isMsb),
    .gt       (chunkGt),
    .lt       (chunkLt)
  );

  assign pmq_out  = result[1];
  assign pmeq_out = result[0];

  // Control FSM with operand capture, chunk index and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pReg      <= '0;
      qReg      <= '0;
      signedReg <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= RES_NONE;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pReg      <= p;
            qReg      <= q;
            signedReg <= signed_mode;
            idx       <= IDXW'(NCHUNK - 1);
            busy      <= 1'b1;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (chunkGt) begin
            result <= RES_GT;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (chunkLt) begin
            result <= RES_LT;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (idx == '0) begin
            result <= RES_EQ;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx - IDXW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mag_comp_seq.sv
// Self-checking bench for mag_comp_seq (WIDTH=16, CHUNK=4) with a
// behavioural reference built from whole-word signed/unsigned comparison.
module tb_mag_comp_seq;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             signedMode;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             pmqOut;
  logic             pmeqOut;

  int testsRun    = 0;
  int testsFailed = 0;

  mag_comp_seq #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_mode(signedMode),
    .p          (p),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .pmq_out    (pmqOut),
    .pmeq_out   (pmeqOut)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected result code from a whole-word compare
  function automatic logic [1:0] refCode(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic sm);
    if (sm) begin
      if ($signed(a) > $signed(b)) return 2'b10;
      if ($signed(a) < $signed(b)) return 2'b01;
      return 2'b11;
    end
    if (a > b) return 2'b10;
    if (a < b) return 2'b01;
    return 2'b11;
  endfunction

  // Expected number of chunks examined: up to the first differing chunk from the top
  function automatic int refSteps(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int mask;
    mask = (1 << CHUNK) - 1;
    for (int c = NCHUNK - 1; c >= 0; c--) begin
      if (((int'(a) >> (c * CHUNK)) & mask) != ((int'(b) >> (c * CHUNK)) & mask))
        return NCHUNK - c;
    end
    return NCHUNK;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present a request and let the start edge go by; bench sits 1 ns after an edge
  task automatic applyStimulus(input logic [WIDTH-1:0] pv, input logic [WIDTH-1:0] qv,
                               input logic sm);
    p          = pv;
    q          = qv;
    signedMode = sm;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Count edges until done, checking busy stays up meanwhile; bounded wait
  task automatic waitDone(output int cycles);
    cycles = 0;
    for (int i = 0; i < NCHUNK + 3; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) return;
      checkOutput("busy_during_compare", 32'(busy), 32'd1);
    end
    checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic runCompare(input string tag, input logic [WIDTH-1:0] pv,
                            input logic [WIDTH-1:0] qv, input logic sm);
    int cycles;
    applyStimulus(pv, qv, sm);
    waitDone(cycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(refSteps(pv, qv)));
    checkOutput({tag, "_code"}, 32'({pmqOut, pmeqOut}), 32'(refCode(pv, qv, sm)));
    checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int               cycles;
    logic [WIDTH-1:0] rp;
    logic [WIDTH-1:0] rq;
    logic             rs;
    int               k;
    logic [1:0]       expCode;
    int               expSteps;

    start      = 1'b0;
    signedMode = 1'b0;
    p          = '0;
    q          = '0;
    rst_n      = 1'b0;
    #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_code", 32'({pmqOut, pmeqOut}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_code", 32'({pmqOut, pmeqOut}), 32'd0);

    // Directed cases
    runCompare("eq_1234", 16'h1234, 16'h1234, 1'b0);
    runCompare("gt_9000", 16'h9000, 16'h1FFF, 1'b0);
    runCompare("signed_neg", 16'h8000, 16'h0001, 1'b1);
    runCompare("unsigned_8000", 16'h8000, 16'h0001, 1'b0);
    runCompare("signed_eqneg", 16'hFFF0, 16'hFFF0, 1'b1);
    runCompare("signed_lowchunk", 16'hF001, 16'hF000, 1'b1);

    // Result holds until next done, with done low
    p = 16'h0000;
    q = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_code", 32'({pmqOut, pmeqOut}), 32'b10);
    checkOutput("hold_done", 32'(done), 32'd0);

    // Second start mid-compare with new operands must be ignored
    applyStimulus(16'h1234, 16'h1235, 1'b0);
    p          = 16'hFFFF;
    q          = 16'h0000;
    signedMode = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cycles);
    checkOutput("ignore_start_latency", 32'(cycles), 32'd3);
    checkOutput("ignore_start_code", 32'({pmqOut, pmeqOut}), 32'b01);

    // Reset in the middle of a 4-chunk compare
    applyStimulus(16'h1234, 16'h1234, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_code", 32'({pmqOut, pmeqOut}), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("midreset_no_done", 32'(done), 32'd0);
      if (i == 1) rst_n = 1'b1;
    end
    runCompare("after_reset", 16'h0001, 16'h0002, 1'b0);

    // Randomized compares with shared high-order prefixes
    for (int n = 0; n < 24; n++) begin
      rp = WIDTH'($urandom);
      k  = $urandom_range(0, NCHUNK);
      rq = rp ^ (WIDTH'($urandom) & WIDTH'((32'd1 << (k * CHUNK)) - 1));
      rs = 1'($urandom);
      runCompare("random", rp, rq, rs);
    end

    // Start held high: alternating equal / greater pairs, no extra idle cycle
    rp         = WIDTH'($urandom);
    p          = rp;
    q          = rp;
    signedMode = 1'b0;
    start      = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      checkOutput("b2b_accept", 32'(busy), 32'd1);
      expCode  = refCode(p, q, 1'b0);
      expSteps = refSteps(p, q);
      if (n % 2 == 0) begin
        rq = WIDTH'($urandom_range(0, 16'hFFFE));
        rp = rq + WIDTH'($urandom_range(1, 16'hFFFF - int'(rq)));
      end else begin
        rp = WIDTH'($urandom);
        rq = rp;
      end
      p = rp;
      q = rq;
      waitDone(cycles);
      checkOutput("b2b_latency", 32'(cycles), 32'(expSteps));
      checkOutput("b2b_code", 32'({pmqOut, pmeqOut}), 32'(expCode));
    end
    start = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mag_comp_seq.md
MAG_COMP_SEQ -- requirements
Module: mag_comp_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of CHUNK, minimum 4.
REQ-002 Parameter CHUNK, default 4, bits compared per clock cycle; SHALL be at least 1.
REQ-003 Derived constant NCHUNK = WIDTH/CHUNK SHALL set the number of compare steps.
REQ-004 Clocking is decided: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request a compare; sampled only in IDLE.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-009 p  input  WIDTH  operand P; sampled with start.
REQ-010 q  input  WIDTH  operand Q; sampled with start.
REQ-011 busy  output  1  high while a compare is in progress.
REQ-012 done  output  1  one-cycle pulse marking a new valid result.
REQ-013 pmq_out  output  1  P greater than or equal to Q.
REQ-014 pmeq_out  output  1  P less than or equal to Q.

Function
REQ-015 Result code {pmq_out, pmeq_out} SHALL be: 11 = equal, 10 = P>Q, 01 = P<Q, 00 = no result since reset.
REQ-016 The FSM SHALL have two states, IDLE and COMPARE, plus a registered done flag.
REQ-017 In IDLE, start=1 at edge k SHALL do all of the following:
- register p, q and signed_mode;
- set chunk index to NCHUNK-1 (MSB chunk);
- enter COMPARE with busy=1 from edge k.
REQ-018 Each COMPARE edge SHALL compare the registered chunk at the current index.
REQ-019 Compare order SHALL be most-significant chunk first.
REQ-020 If the chunks differ, the FSM SHALL latch 10 or 01 and return to IDLE (early exit).
REQ-021 If the chunks are equal and index=0, the FSM SHALL latch 11 and return to IDLE.
REQ-022 Otherwise the FSM SHALL decrement the index and remain in COMPARE.
REQ-023 In signed mode, the MSB chunk SHALL be compared with each operand's top bit inverted; the other chunks SHALL be compared unsigned.
REQ-024 Latency SHALL be m cycles from the start edge to done=1, where m = number of chunks examined (1..NCHUNK).
REQ-025 done and the new result SHALL appear together on the same edge at which busy falls.
REQ-026 Result outputs SHALL hold their value until the next done.
REQ-027 start while busy=1 SHALL be ignored; operand inputs SHALL not be resampled.
REQ-028 start asserted in the done cycle SHALL be accepted, since the FSM is already in IDLE.
REQ-029 Back-to-back compares SHALL sustain one compare per m+0 idle cycles (no dead cycle).
REQ-030 Changes on p, q or signed_mode during COMPARE SHALL not affect the result in flight.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE and clear busy, done, pmq_out and pmeq_out to 0.
REQ-032 Reset SHALL clear the chunk index and operand registers to 0.
REQ-033 Reset mid-compare SHALL abort it with no done pulse.
REQ-034 The first start after rst_n rises SHALL behave exactly as from power-up.

Structure
REQ-035 Shared package mag_comp_pkg SHALL hold:
- the FSM state enum;
- result-code constants RES_EQ, RES_GT, RES_LT, RES_NONE.
REQ-036 The per-chunk compare SHALL be sub-module mag_comp_chunk: combinational, CHUNK-bit, with a signed-MSB flag, outputs gt/lt.
REQ-037 The top level SHALL contain only the FSM, index counter, operand registers and output registers.

Verification (WIDTH=16, CHUNK=4)
REQ-038 Unsigned, P=0x1234, Q=0x1234 -> done 4 cycles after start, code 11.
REQ-039 Unsigned, P=0x9000, Q=0x1FFF -> done after 1 cycle, code 10, busy high for exactly 1 cycle.
REQ-040 Signed, P=0x8000 (-32768), Q=0x0001 -> code 01; the same operands unsigned -> code 10.
REQ-041 start pulsed again mid-compare with different p/q -> ignored; the first compare's result is unchanged.
REQ-042 rst_n asserted on cycle 2 of a 4-cycle compare -> outputs 00, no done; the next compare of 0x0001 vs 0x0002 -> code 01.
REQ-043 start held high continuously with alternating equal and greater operands -> consecutive done pulses with no idle cycle, matching a reference model.
